// File: rtl/clk_div_pkg.sv
// Shared defaults and helpers for the multi-channel clock divider.
package clk_div_pkg;

    localparam int unsigned CDM_CHANNELS    = 4;
    localparam int unsigned CDM_WIDTH       = 16;
    localparam int unsigned CDM_DEFAULT_DIV = 999;

    // Channel-select width: clog2 of the channel count, never below one bit.
    function automatic int unsigned sel_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: counter, active/shadow divisor pair, square-wave and tick outputs.
module clk_div_channel
    import clk_div_pkg::*;
#(
    parameter int unsigned WIDTH       = CDM_WIDTH,
    parameter int unsigned DEFAULT_DIV = CDM_DEFAULT_DIV
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             wr,
    input  logic [WIDTH-1:0] wdata,
    output logic             clkout,
    output logic             tick
);

    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] active_q, active_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic             pending_q, pending_d;
    logic             clkout_q, clkout_d;
    logic             tick_q, tick_d;

    always_comb begin
        count_d   = count_q;
        active_d  = active_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        clkout_d  = clkout_q;
        tick_d    = 1'b0;

        if (clr) begin
            count_d  = '0;
            clkout_d = 1'b0;
            if (pending_q) begin
                active_d  = shadow_q;
                pending_d = 1'b0;
            end
        end else if (en) begin
            if (count_q >= active_q) begin
                count_d   = '0;
                clkout_d  = ~clkout_q;
                tick_d    = 1'b1;
                active_d  = shadow_q;
                pending_d = 1'b0;
            end else begin
                count_d = count_q + WIDTH'(1);
            end
        end else if (pending_q) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end

        // A write lands after the wrap/apply above, so it always survives as pending.
        if (wr) begin
            shadow_d  = wdata;
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q   <= '0;
            active_q  <= WIDTH'(DEFAULT_DIV);
            shadow_q  <= WIDTH'(DEFAULT_DIV);
            pending_q <= 1'b0;
            clkout_q  <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            count_q   <= count_d;
            active_q  <= active_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            clkout_q  <= clkout_d;
            tick_q    <= tick_d;
        end
    end

    assign clkout = clkout_q;
    assign tick   = tick_q;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider: decodes divisor writes and fans out
// enable and sync_clr to one clk_div_channel per output.
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int unsigned CHANNELS    = CDM_CHANNELS,
    parameter int unsigned WIDTH       = CDM_WIDTH,
    parameter int unsigned DEFAULT_DIV = CDM_DEFAULT_DIV,
    parameter int unsigned SEL_W       = sel_width(CHANNELS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] enable,
    input  logic                sync_clr,
    input  logic                div_wr,
    input  logic [SEL_W-1:0]    div_sel,
    input  logic [WIDTH-1:0]    div_data,
    output logic [CHANNELS-1:0] clkout,
    output logic [CHANNELS-1:0] tick
);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic wr_ch;

        // Selects at or above CHANNELS match no channel and are dropped here.
        assign wr_ch = div_wr && (div_sel == SEL_W'(g));

        clk_div_channel #(
            .WIDTH       (WIDTH),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk    (clk),
            .rst    (rst),
            .en     (enable[g]),
            .clr    (sync_clr),
            .wr     (wr_ch),
            .wdata  (div_data),
            .clkout (clkout[g]),
            .tick   (tick[g])
        );
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi: a per-cycle vector table plus hand-written
// sequences for the long-period, wrap-collision, sync_clr and reset cases.
module tb_clk_div_multi;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  enable;
    logic        sync_clr;
    logic        div_wr;
    logic [1:0]  div_sel;
    logic [15:0] div_data;
    logic [3:0]  clkout;
    logic [3:0]  tick;

    // Three-channel instance so an out-of-range select is representable.
    logic        rst3;
    logic [2:0]  en3;
    logic        wr3;
    logic [1:0]  sel3;
    logic [7:0]  data3;
    logic [2:0]  clkout3;
    logic [2:0]  tick3;

    int tests  = 0;
    int errors = 0;

    always #5 clk = ~clk;

    clk_div_multi #(
        .CHANNELS    (4),
        .WIDTH       (16),
        .DEFAULT_DIV (999)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .sync_clr (sync_clr),
        .div_wr   (div_wr),
        .div_sel  (div_sel),
        .div_data (div_data),
        .clkout   (clkout),
        .tick     (tick)
    );

    clk_div_multi #(
        .CHANNELS    (3),
        .WIDTH       (8),
        .DEFAULT_DIV (3)
    ) u_dut3 (
        .clk      (clk),
        .rst      (rst3),
        .enable   (en3),
        .sync_clr (1'b0),
        .div_wr   (wr3),
        .div_sel  (sel3),
        .div_data (data3),
        .clkout   (clkout3),
        .tick     (tick3)
    );

    typedef struct {
        logic        rst;
        logic [3:0]  en;
        logic        wr;
        logic [1:0]  sel;
        logic [15:0] data;
        logic [3:0]  exp_clk;
        logic [3:0]  exp_tick;
    } vec_t;

    vec_t vecs[23];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic wait_toggle(input int ch, input int maxc, output int n);
        logic prev;
        prev = clkout[ch];
        n = 0;
        while (n <= maxc) begin
            step();
            n++;
            if (clkout[ch] !== prev) break;
        end
    endtask

    initial begin
        int n;
        int rise[4];
        int exp_rise[4];
        logic others;

        rst = 1'b1; enable = '0; sync_clr = 1'b0; div_wr = 1'b0; div_sel = '0; div_data = '0;
        rst3 = 1'b1; en3 = '0; wr3 = 1'b0; sel3 = '0; data3 = '0;

        // ---- reset values and default 1000-cycle half-period ----
        step();
        check("rst clkout", 32'(clkout), 0);
        check("rst tick", 32'(tick), 0);
        rst = 1'b0;
        enable = 4'b0001;
        n = 0;
        others = 1'b0;
        do begin
            step(); n++;
            others = others | (|clkout[3:1]) | (|tick[3:1]);
        end while (clkout[0] !== 1'b1 && n < 1100);
        check("default rise edge", 32'(n), 1000);
        check("tick at rise", 32'(tick[0]), 1);
        step(); n++;
        check("tick one cycle", 32'(tick[0]), 0);
        do begin
            step(); n++;
            others = others | (|clkout[3:1]) | (|tick[3:1]);
        end while (clkout[0] !== 1'b0 && n < 2100);
        check("default fall edge", 32'(n), 2000);
        check("tick at fall", 32'(tick[0]), 1);
        check("idle channels quiet", 32'(others), 0);

        // ---- vector table: reload at wrap on ch1, zero divisor and disable on ch2 ----
        vecs[0]  = '{1'b1, 4'b0000, 1'b0, 2'd0, 16'd0, 4'b0000, 4'b0000};
        vecs[1]  = '{1'b0, 4'b0000, 1'b1, 2'd1, 16'd3, 4'b0000, 4'b0000};
        vecs[2]  = '{1'b0, 4'b0000, 1'b0, 2'd0, 16'd0, 4'b0000, 4'b0000};
        vecs[3]  = '{1'b0, 4'b0010, 1'b0, 2'd0, 16'd0, 4'b0000, 4'b0000};
        vecs[4]  = '{1'b0, 4'b0010, 1'b0, 2'd0, 16'd0, 4'b0000, 4'b0000};
        vecs[5]  = '{1'b0, 4'b0010, 1'b1, 2'd1, 16'd1, 4'b0000, 4'b0000};
        vecs[6]  = '{1'b0, 4'b0010, 1'b0, 2'd0, 16'd0, 4'b0010, 4'b0010};
        vecs[7]  = '{1'b0, 4'b0010, 1'b0, 2'd0, 16'd0, 4'b0010, 4'b0000};
        vecs[8]  = '{1'b0, 4'b0010, 1'b0, 2'd0, 16'd0, 4'b0000, 4'b0010};
        vecs[9]  = '{1'b0, 4'b0010, 1'b0, 2'd0, 16'd0, 4'b0000, 4'b0000};
        vecs[10] = '{1'b0, 4'b0010, 1'b0, 2'd0, 16'd0, 4'b0010, 4'b0010};
        vecs[11] = '{1'b0, 4'b0000, 1'b1, 2'd2, 16'd0, 4'b0010, 4'b0000};
        vecs[12] = '{1'b0, 4'b0000, 1'b0, 2'd0, 16'd0, 4'b0010, 4'b0000};
        vecs[13] = '{1'b0, 4'b0100, 1'b0, 2'd0, 16'd0, 4'b0110, 4'b0100};
        vecs[14] = '{1'b0, 4'b0100, 1'b0, 2'd0, 16'd0, 4'b0010, 4'b0100};
        vecs[15] = '{1'b0, 4'b0100, 1'b0, 2'd0, 16'd0, 4'b0110, 4'b0100};
        vecs[16] = '{1'b0, 4'b0000, 1'b0, 2'd0, 16'd0, 4'b0110, 4'b0000};
        vecs[17] = '{1'b0, 4'b0000, 1'b0, 2'd0, 16'd0, 4'b0110, 4'b0000};
        vecs[18] = '{1'b0, 4'b0000, 1'b1, 2'd2, 16'd2, 4'b0110, 4'b0000};
        vecs[19] = '{1'b0, 4'b0000, 1'b0, 2'd0, 16'd0, 4'b0110, 4'b0000};
        vecs[20] = '{1'b0, 4'b0100, 1'b0, 2'd0, 16'd0, 4'b0110, 4'b0000};
        vecs[21] = '{1'b0, 4'b0100, 1'b0, 2'd0, 16'd0, 4'b0110, 4'b0000};
        vecs[22] = '{1'b0, 4'b0100, 1'b0, 2'd0, 16'd0, 4'b0010, 4'b0100};

        for (int i = 0; i < 23; i++) begin
            rst = vecs[i].rst; enable = vecs[i].en; div_wr = vecs[i].wr;
            div_sel = vecs[i].sel; div_data = vecs[i].data;
            step();
            check($sformatf("vec%0d clkout", i), 32'(clkout), 32'(vecs[i].exp_clk));
            check($sformatf("vec%0d tick", i), 32'(tick), 32'(vecs[i].exp_tick));
        end
        div_wr = 1'b0;

        // ---- write on the exact wrap cycle of ch0 ----
        rst = 1'b1; enable = '0; step();
        rst = 1'b0; div_wr = 1'b1; div_sel = 2'd0; div_data = 16'd2; step();
        div_wr = 1'b0; step();
        enable = 4'b0001; step(); step();
        div_wr = 1'b1; div_data = 16'd5; step();
        div_wr = 1'b0;
        check("wrap-write rise", 32'(clkout[0]), 1);
        wait_toggle(0, 20, n);
        check("wrap-write old div", 32'(n), 3);
        wait_toggle(0, 20, n);
        check("wrap-write new div", 32'(n), 6);

        // ---- out-of-range select on the 3-channel instance ----
        step();
        rst3 = 1'b0; wr3 = 1'b1; sel3 = 2'd3; data3 = 8'd0; step();
        wr3 = 1'b0; step();
        en3 = 3'b111;
        step(); step(); step();
        check("sel3 before rise", 32'(clkout3), 0);
        step();
        check("sel3 rise", 32'(clkout3), 32'h7);
        check("sel3 tick", 32'(tick3), 32'h7);
        step(); step(); step();
        check("sel3 high hold", 32'(clkout3), 32'h7);
        step();
        check("sel3 fall", 32'(clkout3), 0);

        // ---- sync_clr realigns channels at divs 2/5/7/11 ----
        rst = 1'b1; enable = '0; step();
        rst = 1'b0;
        div_wr = 1'b1; div_sel = 2'd0; div_data = 16'd2;  step();
        div_sel = 2'd1; div_data = 16'd5;  step();
        div_sel = 2'd2; div_data = 16'd7;  step();
        div_sel = 2'd3; div_data = 16'd11; step();
        div_wr = 1'b0; step();
        enable = 4'b1111;
        repeat (17) step();
        sync_clr = 1'b1; step();
        check("sync_clr clkout", 32'(clkout), 0);
        check("sync_clr tick", 32'(tick), 0);
        sync_clr = 1'b0;
        exp_rise = '{3, 6, 8, 12};
        rise = '{0, 0, 0, 0};
        for (int k = 1; k <= 14; k++) begin
            step();
            for (int c = 0; c < 4; c++)
                if (rise[c] == 0 && clkout[c] === 1'b1) rise[c] = k;
        end
        for (int c = 0; c < 4; c++)
            check($sformatf("sync rise ch%0d", c), 32'(rise[c]), 32'(exp_rise[c]));

        // ---- reset with a pending write outstanding ----
        div_wr = 1'b1; div_sel = 2'd0; div_data = 16'd0; step();
        div_wr = 1'b0; rst = 1'b1; step();
        check("mid rst clkout", 32'(clkout), 0);
        check("mid rst tick", 32'(tick), 0);
        rst = 1'b0; enable = 4'b0001;
        wait_toggle(0, 1100, n);
        check("post rst rise", 32'(n), 1000);
        wait_toggle(0, 1100, n);
        check("post rst fall", 32'(n), 1000);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
